// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Start/stop/lap/clear sequencer driving a BCD mm:ss.mmm time chain that
//   advances on a 1 ms strobe. The chain saturates at MIN_MAX:59.999 and
//   raises a sticky overflow flag.
//   Optional feature macro: STOPWATCH_LAP_EN adds the LAP state and the lap
//   registers that freeze the display while the live chain keeps counting.
//   With the macro undefined, btn_lr is ignored in RUN and lap_active is 0.
//   Button semantics: btn_ss and btn_lr are single-cycle debounced pulses with
//   no handshake; a press is acted on in the cycle it is high, the resulting
//   state is visible from the next cycle, and btn_ss wins over btn_lr.
module stopwatch_ctrl #(
    parameter int MIN_MAX = 59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1ms,
    input  logic        btn_ss,
    input  logic        btn_lr,
    output logic [11:0] disp_ms,
    output logic [7:0]  disp_sec,
    output logic [7:0]  disp_min,
    output logic        sec_pulse,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    // Last valid minute value as two BCD digits.
    localparam logic [3:0] MIN_TENS = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_ONES = 4'(MIN_MAX % 10);
    localparam logic [7:0] MIN_LAST = {MIN_TENS, MIN_ONES};

`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;
`endif

    state_t      state_q;
    state_t      state_d;

    // Live time chain, BCD digits throughout.
    logic [11:0] ms_q;
    logic [7:0]  sec_q;
    logic [7:0]  min_q;
    logic [11:0] ms_d;
    logic [7:0]  sec_d;
    logic [7:0]  min_d;

    logic        overflow_q;
    logic        sec_pulse_q;

    logic        count_en;
    logic        ms_wrap;
    logic        at_max;
    logic        saturate;
    logic        clear_all;

`ifdef STOPWATCH_LAP_EN
    logic [11:0] lap_ms_q;
    logic [7:0]  lap_sec_q;
    logic [7:0]  lap_min_q;
    logic        lap_capture;
`endif

    // The chain only moves while the current (not next) state is counting.
`ifdef STOPWATCH_LAP_EN
    assign count_en = tick_1ms && ((state_q == ST_RUN) || (state_q == ST_LAP));
`else
    assign count_en = tick_1ms && (state_q == ST_RUN);
`endif

    assign ms_wrap  = (ms_q == 12'h999);
    assign at_max   = ms_wrap && (sec_q == 8'h59) && (min_q == MIN_LAST);
    assign saturate = count_en && at_max;

    // Next-state decode; saturation forces PAUSE regardless of any press.
    always_comb begin
        state_d   = state_q;
        clear_all = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_capture = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (btn_ss) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (btn_ss) begin
                    state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (btn_lr) begin
                    state_d     = ST_LAP;
                    lap_capture = 1'b1;
`endif
                end
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (btn_ss) begin
                    state_d = ST_PAUSE;
                end else if (btn_lr) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_PAUSE: begin
                // After overflow only a clear may leave PAUSE.
                if (btn_ss && !overflow_q) begin
                    state_d = ST_RUN;
                end else if (btn_lr) begin
                    state_d   = ST_IDLE;
                    clear_all = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (saturate) begin
            state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
            lap_capture = 1'b0;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ripple-carry BCD increment of ms -> sec -> min; only used below the limit.
    always_comb begin
        ms_d  = ms_q;
        sec_d = sec_q;
        min_d = min_q;
        if (ms_q[3:0] != 4'd9) begin
            ms_d[3:0] = ms_q[3:0] + 4'd1;
        end else begin
            ms_d[3:0] = 4'd0;
            if (ms_q[7:4] != 4'd9) begin
                ms_d[7:4] = ms_q[7:4] + 4'd1;
            end else begin
                ms_d[7:4] = 4'd0;
                if (ms_q[11:8] != 4'd9) begin
                    ms_d[11:8] = ms_q[11:8] + 4'd1;
                end else begin
                    ms_d[11:8] = 4'd0;
                    if (sec_q[3:0] != 4'd9) begin
                        sec_d[3:0] = sec_q[3:0] + 4'd1;
                    end else begin
                        sec_d[3:0] = 4'd0;
                        if (sec_q[7:4] != 4'd5) begin
                            sec_d[7:4] = sec_q[7:4] + 4'd1;
                        end else begin
                            sec_d[7:4] = 4'd0;
                            if (min_q[3:0] != 4'd9) begin
                                min_d[3:0] = min_q[3:0] + 4'd1;
                            end else begin
                                min_d[3:0] = 4'd0;
                                min_d[7:4] = min_q[7:4] + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Live chain, overflow flag and rollover pulse; registers hold unless
    // counting or clearing so a paused value stays put.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ms_q        <= 12'h000;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            overflow_q  <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else if (clear_all) begin
            ms_q        <= 12'h000;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            overflow_q  <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            sec_pulse_q <= 1'b0;
            if (count_en) begin
                if (at_max) begin
                    overflow_q <= 1'b1;
                end else begin
                    ms_q        <= ms_d;
                    sec_q       <= sec_d;
                    min_q       <= min_d;
                    sec_pulse_q <= ms_wrap;
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap registers take the pre-increment live value on entry to LAP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lap_ms_q  <= 12'h000;
            lap_sec_q <= 8'h00;
            lap_min_q <= 8'h00;
        end else if (clear_all) begin
            lap_ms_q  <= 12'h000;
            lap_sec_q <= 8'h00;
            lap_min_q <= 8'h00;
        end else if (lap_capture) begin
            lap_ms_q  <= ms_q;
            lap_sec_q <= sec_q;
            lap_min_q <= min_q;
        end
    end

    assign lap_active = (state_q == ST_LAP);
    assign running    = (state_q == ST_RUN) || (state_q == ST_LAP);
`else
    assign lap_active = 1'b0;
    assign running    = (state_q == ST_RUN);
`endif

    assign overflow  = overflow_q;
    assign sec_pulse = sec_pulse_q;

    // Display select: frozen lap value while in LAP, live chain otherwise.
    always_comb begin
        disp_ms  = ms_q;
        disp_sec = sec_q;
        disp_min = min_q;
`ifdef STOPWATCH_LAP_EN
        if (lap_active) begin
            disp_ms  = lap_ms_q;
            disp_sec = lap_sec_q;
            disp_min = lap_min_q;
        end
`endif
    end

endmodule
